// File: rtl/scan_chain_slot.sv
// Scan-chain responder slot: oversamples upstream chain, shifts, captures, latches.
// Ports: chain in/out (clk/data/select/latch), design I/O, err_clr, diagnostics.
module scan_chain_slot #(
  parameter int NUM_IOS     = 8,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               scan_clk_in,
  input  logic               scan_data_in,
  input  logic               scan_select_in,
  input  logic               scan_latch_en_in,
  output logic               scan_clk_out,
  output logic               scan_data_out,
  output logic               scan_select_out,
  output logic               scan_latch_en_out,
  input  logic [NUM_IOS-1:0] design_outputs,
  output logic [NUM_IOS-1:0] design_inputs,
  input  logic               err_clr,
  output logic [CNT_W-1:0]   edge_cnt,
  output logic [CNT_W-1:0]   latch_cnt,
  output logic               frame_err
);

  localparam int BW = (NUM_IOS > 2) ? $clog2(NUM_IOS) : 1;
  localparam int IW = $clog2(SYNC_STAGES + 2);
  localparam logic [BW-1:0] LAST = BW'(NUM_IOS - 1);
  localparam logic [IW-1:0] ARM  = IW'(SYNC_STAGES + 1);

  // lane order: {lat, sel, data, clk}
  logic [SYNC_STAGES-1:0][3:0] sync_q, sync_d;
  logic                        p_clk_q, p_clk_d;
  logic                        p_lat_q, p_lat_d;
  logic [IW-1:0]               init_q, init_d;
  logic [NUM_IOS-1:0]          shift_q, shift_d;
  logic [BW-1:0]               bit_cnt_q, bit_cnt_d;
  logic                        out_bit_q, out_bit_d;
  logic [NUM_IOS-1:0]          din_q, din_d;
  logic [2:0]                  fwd_q, fwd_d;
  logic [CNT_W-1:0]            edge_q, edge_d;
  logic [CNT_W-1:0]            lcnt_q, lcnt_d;
  logic                        ferr_q, ferr_d;

  logic s_clk, s_data, s_sel, s_lat;
  logic armed, rise_clk, fall_clk, rise_lat;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0],
              {scan_latch_en_in, scan_select_in,
               scan_data_in, scan_clk_in}};
    s_clk  = sync_q[SYNC_STAGES-1][0];
    s_data = sync_q[SYNC_STAGES-1][1];
    s_sel  = sync_q[SYNC_STAGES-1][2];
    s_lat  = sync_q[SYNC_STAGES-1][3];

    // edges are ignored until the synchronizers hold real pad values
    armed    = (init_q == ARM);
    init_d   = armed ? init_q : init_q + IW'(1);
    rise_clk = armed & s_clk & ~p_clk_q;
    fall_clk = armed & ~s_clk & p_clk_q;
    rise_lat = armed & s_lat & ~p_lat_q;

    p_clk_d   = s_clk;
    p_lat_d   = s_lat;
    fwd_d     = {s_lat, s_sel, s_clk};
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    out_bit_d = out_bit_q;
    din_d     = din_q;
    edge_d    = edge_q;
    lcnt_d    = lcnt_q;
    ferr_d    = ferr_q;

    if (rise_clk) begin
      edge_d = edge_q + CNT_W'(1);
      if (s_sel) begin
        shift_d   = design_outputs;
        bit_cnt_d = '0;
      end else begin
        shift_d   = {shift_q[NUM_IOS-2:0], s_data};
        bit_cnt_d = (bit_cnt_q == LAST) ? '0
                                        : bit_cnt_q + BW'(1);
      end
    end

    if (fall_clk)
      out_bit_d = shift_q[NUM_IOS-1];

    if (err_clr)
      ferr_d = 1'b0;

    // latch sees the pre-shift register and bit count
    if (rise_lat) begin
      din_d = shift_q;
      if (~&lcnt_q)
        lcnt_d = lcnt_q + CNT_W'(1);
      if (bit_cnt_q != '0)
        ferr_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q    <= '0;
      p_clk_q   <= 1'b0;
      p_lat_q   <= 1'b0;
      init_q    <= '0;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      out_bit_q <= 1'b0;
      din_q     <= '0;
      fwd_q     <= '0;
      edge_q    <= '0;
      lcnt_q    <= '0;
      ferr_q    <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      p_clk_q   <= p_clk_d;
      p_lat_q   <= p_lat_d;
      init_q    <= init_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      out_bit_q <= out_bit_d;
      din_q     <= din_d;
      fwd_q     <= fwd_d;
      edge_q    <= edge_d;
      lcnt_q    <= lcnt_d;
      ferr_q    <= ferr_d;
    end
  end

  assign scan_clk_out      = fwd_q[0];
  assign scan_select_out   = fwd_q[1];
  assign scan_latch_en_out = fwd_q[2];
  assign scan_data_out     = out_bit_q;
  assign design_inputs     = din_q;
  assign edge_cnt          = edge_q;
  assign latch_cnt         = lcnt_q;
  assign frame_err         = ferr_q;

endmodule

// File: tb/tb_scan_chain_slot.sv
// Directed bench for scan_chain_slot: shift/latch table plus
// capture, pass-through, latency, framing and reset sequences.
module tb_scan_chain_slot;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        scan_clk_in = 1'b0;
  logic        scan_data_in = 1'b0;
  logic        scan_select_in = 1'b0;
  logic        scan_latch_en_in = 1'b0;
  logic        scan_clk_out;
  logic        scan_data_out;
  logic        scan_select_out;
  logic        scan_latch_en_out;
  logic [7:0]  design_outputs = 8'h00;
  logic [7:0]  design_inputs;
  logic        err_clr = 1'b0;
  logic [15:0] edge_cnt;
  logic [15:0] latch_cnt;
  logic        frame_err;

  int checks = 0;
  int errors = 0;
  int ecnt = 0;
  int lcnt = 0;

  scan_chain_slot #(
    .NUM_IOS(8), .SYNC_STAGES(2), .CNT_W(16)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .scan_clk_in(scan_clk_in),
    .scan_data_in(scan_data_in),
    .scan_select_in(scan_select_in),
    .scan_latch_en_in(scan_latch_en_in),
    .scan_clk_out(scan_clk_out),
    .scan_data_out(scan_data_out),
    .scan_select_out(scan_select_out),
    .scan_latch_en_out(scan_latch_en_out),
    .design_outputs(design_outputs),
    .design_inputs(design_inputs),
    .err_clr(err_clr),
    .edge_cnt(edge_cnt),
    .latch_cnt(latch_cnt),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] val;
    logic [7:0] exp_di;
    int         exp_edge;
    int         exp_latch;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  task automatic pulse(input logic d, input logic sel,
                       input bit lat_chk);
    @(negedge clk);
    scan_data_in = d;
    scan_select_in = sel;
    scan_clk_in = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      if (lat_chk)
        chk("clk_out_rise", 32'(scan_clk_out), 32'(i >= 3));
    end
    scan_clk_in = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      if (lat_chk)
        chk("clk_out_fall", 32'(scan_clk_out), 32'(i < 3));
    end
    scan_select_in = 1'b0;
    ecnt++;
  endtask

  task automatic shift_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) pulse(v[i], 1'b0, 1'b0);
  endtask

  task automatic latch();
    @(negedge clk);
    scan_latch_en_in = 1'b1;
    repeat (4) @(negedge clk);
    scan_latch_en_in = 1'b0;
    repeat (4) @(negedge clk);
    lcnt++;
  endtask

  task automatic clr_pulse();
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
  endtask

  initial begin
    logic [15:0] pat;
    logic [8:0]  cap_exp;

    vecs[0] = '{8'hA5, 8'hA5, 8, 1};
    vecs[1] = '{8'h3C, 8'h3C, 16, 2};
    vecs[2] = '{8'hFF, 8'hFF, 24, 3};
    vecs[3] = '{8'h00, 8'h00, 32, 4};

    // chain clock and latch held high across reset release
    scan_clk_in = 1'b1;
    scan_latch_en_in = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_di", 32'(design_inputs), 0);
    chk("rst_edge", 32'(edge_cnt), 0);
    chk("rst_latch", 32'(latch_cnt), 0);
    chk("rst_ferr", 32'(frame_err), 0);
    chk("rst_clk_out", 32'(scan_clk_out), 0);
    chk("rst_lat_out", 32'(scan_latch_en_out), 0);
    chk("rst_dout", 32'(scan_data_out), 0);
    reset_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("arm_edge", 32'(edge_cnt), 0);
    chk("arm_latch", 32'(latch_cnt), 0);
    chk("arm_di", 32'(design_inputs), 0);
    chk("fwd_clk_hi", 32'(scan_clk_out), 1);
    scan_clk_in = 1'b0;
    scan_latch_en_in = 1'b0;
    repeat (6) @(negedge clk);

    // table: full 8-bit shift then latch
    for (int v = 0; v < 4; v++) begin
      shift_byte(vecs[v].val);
      latch();
      chk("tbl_di", 32'(design_inputs), 32'(vecs[v].exp_di));
      chk("tbl_edge", 32'(edge_cnt), 32'(vecs[v].exp_edge));
      chk("tbl_latch", 32'(latch_cnt), 32'(vecs[v].exp_latch));
      chk("tbl_ferr", 32'(frame_err), 0);
    end

    // capture 0x3C then shift out zeros
    cap_exp = 9'b001111000;
    design_outputs = 8'h3C;
    pulse(1'b0, 1'b1, 1'b0);
    chk("cap_out0", 32'(scan_data_out), 32'(cap_exp[8]));
    for (int i = 1; i <= 8; i++) begin
      pulse(1'b0, 1'b0, 1'b0);
      chk("cap_out", 32'(scan_data_out), 32'(cap_exp[8-i]));
    end
    chk("cap_di_hold", 32'(design_inputs), 32'h00);

    // pass-through: bit k emerges after pulse k+8
    pat = 16'hB38E;
    for (int j = 0; j < 16; j++) begin
      pulse(pat[15-j], 1'b0, j == 0);
      if (j >= 7)
        chk("pass_out", 32'(scan_data_out),
            32'(pat[15-(j-7)]));
    end
    chk("pass_edge", 32'(edge_cnt), 32'(ecnt));

    // framing error after 5 bits
    for (int i = 0; i < 5; i++) pulse(1'b0, 1'b0, 1'b0);
    latch();
    chk("frm_di", 32'(design_inputs), 32'hC0);
    chk("frm_err_set", 32'(frame_err), 1);
    chk("frm_latch", 32'(latch_cnt), 32'(lcnt));
    clr_pulse();
    @(negedge clk);
    chk("frm_err_clr", 32'(frame_err), 0);

    // latch and err_clr together: set wins
    @(negedge clk);
    scan_latch_en_in = 1'b1;
    @(negedge clk);
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    repeat (2) @(negedge clk);
    scan_latch_en_in = 1'b0;
    repeat (4) @(negedge clk);
    lcnt++;
    chk("frm_err_prio", 32'(frame_err), 1);
    clr_pulse();
    @(negedge clk);
    chk("frm_err_clr2", 32'(frame_err), 0);

    // simultaneous clock rise and latch rise, shift_reg=0x81
    design_outputs = 8'h81;
    pulse(1'b0, 1'b1, 1'b0);
    @(negedge clk);
    scan_data_in = 1'b0;
    scan_clk_in = 1'b1;
    scan_latch_en_in = 1'b1;
    repeat (4) @(negedge clk);
    scan_clk_in = 1'b0;
    scan_latch_en_in = 1'b0;
    repeat (4) @(negedge clk);
    ecnt++;
    lcnt++;
    chk("sim_di", 32'(design_inputs), 32'h81);
    chk("sim_ferr", 32'(frame_err), 0);
    latch();
    chk("sim_di_post", 32'(design_inputs), 32'h02);
    chk("sim_ferr_post", 32'(frame_err), 1);
    chk("sim_edge", 32'(edge_cnt), 32'(ecnt));
    chk("sim_latch", 32'(latch_cnt), 32'(lcnt));

    // reset mid-shift
    for (int i = 0; i < 3; i++) pulse(1'b1, 1'b0, 1'b0);
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    chk("mid_di", 32'(design_inputs), 0);
    chk("mid_edge", 32'(edge_cnt), 0);
    chk("mid_ferr", 32'(frame_err), 0);
    reset_n = 1'b1;
    repeat (6) @(negedge clk);
    latch();
    chk("mid_di_lost", 32'(design_inputs), 0);
    chk("mid_latch", 32'(latch_cnt), 1);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
